// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch-side PC sequencer: FSM states, redirect
// priority ranks and the sequential increment.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } seq_state_e;

    // Numeric order is the arbitration order: a larger rank wins.
    typedef enum logic [1:0] {
        PRI_NONE = 2'd0,
        PRI_BR   = 2'd1,
        PRI_MRET = 2'd2,
        PRI_TRAP = 2'd3
    } redir_pri_e;

    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/pcsum.sv
// 32-bit modulo-2^32 address adder used for every PC-related sum.
module pcsum (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential advance, branch/trap/mret redirects, and
// holding a refused request stable while redirects queue in one pending slot.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_ready,
    output logic        if_valid,
    output logic [31:0] pc,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_base,
    input  logic [31:0] br_offset,
    input  logic        br_jalr,
    input  logic        trap,
    input  logic [31:0] trap_vec,
    input  logic        mret,
    input  logic [31:0] mepc,
    output logic        misalign
);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        pend_vld_q, pend_vld_d;
    redir_pri_e  pend_pri_q, pend_pri_d;
    logic        misalign_q, misalign_d;

    logic [31:0] pc_inc;
    logic [31:0] br_sum;
    logic [31:0] br_tgt;
    logic        br_mis;
    redir_pri_e  in_pri;
    logic [31:0] in_tgt;
    logic        mrg_vld;
    logic [31:0] mrg_tgt;
    redir_pri_e  mrg_pri;

    pcsum u_seq_add (
        .a_i   (pc_q),
        .b_i   (PC_INC),
        .sum_o (pc_inc)
    );

    pcsum u_br_add (
        .a_i   (br_base),
        .b_i   (br_offset),
        .sum_o (br_sum)
    );

    // Arbitrate this cycle's redirect, then fold it into the pending slot.
    always_comb begin
        br_tgt = br_jalr ? {br_sum[31:1], 1'b0} : br_sum;
        br_mis = (br_tgt[1:0] != 2'b00);
        in_pri = PRI_NONE;
        in_tgt = pc_q;
        if (trap) begin
            in_pri = PRI_TRAP;
            in_tgt = trap_vec;
        end else if (mret) begin
            in_pri = PRI_MRET;
            in_tgt = mepc;
        end else if (br_taken) begin
            in_pri = PRI_BR;
            in_tgt = br_mis ? trap_vec : br_tgt;
        end

        mrg_vld = pend_vld_q;
        mrg_tgt = pend_tgt_q;
        mrg_pri = pend_pri_q;
        if ((in_pri != PRI_NONE) && (!pend_vld_q || (in_pri >= pend_pri_q))) begin
            mrg_vld = 1'b1;
            mrg_tgt = in_tgt;
            mrg_pri = in_pri;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        pend_vld_d = pend_vld_q;
        pend_pri_d = pend_pri_q;
        misalign_d = 1'b0;
        if_valid   = 1'b0;
        case (state_q)
            ST_BOOT: begin
                pc_d       = RESET_VEC;
                pend_vld_d = 1'b0;
                pend_pri_d = PRI_NONE;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if_valid   = 1'b1;
                misalign_d = (in_pri == PRI_BR) && br_mis;
                if (in_pri != PRI_NONE) begin
                    pc_d = in_tgt;
                end else if (!if_ready) begin
                    state_d = ST_HOLD;
                end else if (!stall) begin
                    pc_d = pc_inc;
                end
            end
            ST_HOLD: begin
                if_valid   = 1'b1;
                misalign_d = (in_pri == PRI_BR) && br_mis;
                if (if_ready) begin
                    pc_d       = mrg_vld ? mrg_tgt : (stall ? pc_q : pc_inc);
                    pend_vld_d = 1'b0;
                    pend_pri_d = PRI_NONE;
                    state_d    = ST_RUN;
                end else begin
                    pend_vld_d = mrg_vld;
                    pend_tgt_d = mrg_tgt;
                    pend_pri_d = mrg_pri;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            pend_tgt_q <= RESET_VEC;
            pend_vld_q <= 1'b0;
            pend_pri_q <= PRI_NONE;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            pend_vld_q <= pend_vld_d;
            pend_pri_q <= pend_pri_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc       = pc_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a fetch-behaviour reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_ready = 1'b1;
    logic        if_valid;
    logic [31:0] pc;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_base = '0;
    logic [31:0] br_offset = '0;
    logic        br_jalr = 1'b0;
    logic        trap = 1'b0;
    logic [31:0] trap_vec = '0;
    logic        mret = 1'b0;
    logic [31:0] mepc = '0;
    logic        misalign;

    int n_chk = 0;
    int n_fail = 0;

    pc_sequencer #(.RESET_VEC(RV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_ready  (if_ready),
        .if_valid  (if_valid),
        .pc        (pc),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_base   (br_base),
        .br_offset (br_offset),
        .br_jalr   (br_jalr),
        .trap      (trap),
        .trap_vec  (trap_vec),
        .mret      (mret),
        .mepc      (mepc),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the fetch port must show, from the behavioural rules.
    logic [31:0] m_pc = RV;
    bit          m_booting = 1'b1;
    bit          m_waiting = 1'b0;
    bit          m_mis = 1'b0;
    bit          m_pend = 1'b0;
    int          m_prank = 0;
    logic [31:0] m_ptgt = '0;

    always @(posedge clk or negedge rst_n) begin
        int          rank;
        logic [31:0] tgt;
        logic [31:0] bsum;
        bit          bad;
        if (!rst_n) begin
            m_pc = RV; m_booting = 1; m_waiting = 0; m_mis = 0; m_pend = 0; m_prank = 0;
        end else if (m_booting) begin
            m_pc = RV; m_booting = 0; m_mis = 0;
        end else begin
            bsum = br_base + br_offset;
            if (br_jalr) bsum = bsum & 32'hFFFF_FFFE;
            bad = (bsum % 4) != 0;
            rank = 0; tgt = '0;
            if (trap) begin rank = 3; tgt = trap_vec; end
            else if (mret) begin rank = 2; tgt = mepc; end
            else if (br_taken) begin rank = 1; tgt = bad ? trap_vec : bsum; end
            m_mis = br_taken && !trap && !mret && bad;
            if (!m_waiting) begin
                if (rank > 0) m_pc = tgt;
                else if (!if_ready) m_waiting = 1;
                else if (!stall) m_pc = m_pc + 4;
            end else begin
                if (rank > 0 && (!m_pend || rank >= m_prank)) begin
                    m_pend = 1; m_prank = rank; m_ptgt = tgt;
                end
                if (if_ready) begin
                    m_pc = m_pend ? m_ptgt : (stall ? m_pc : m_pc + 4);
                    m_pend = 0; m_prank = 0; m_waiting = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("model_pc", pc, m_pc);
        check("model_if_valid", {31'd0, if_valid}, {31'd0, rst_n && !m_booting});
        check("model_misalign", {31'd0, misalign}, {31'd0, m_mis});
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clr;
        br_taken = 0; br_jalr = 0; trap = 0; mret = 0; stall = 0;
    endtask

    initial begin
        step(2);
        check("reset_pc", pc, RV);
        check("reset_valid", {31'd0, if_valid}, 32'd0);
        rst_n = 1;
        #1 check("boot_valid", {31'd0, if_valid}, 32'd0);
        check("boot_pc", pc, 32'h0);
        step(1); check("run_pc0", pc, 32'h0); check("run_valid", {31'd0, if_valid}, 32'd1);
        step(1); check("seq_4", pc, 32'h4);
        step(1); check("seq_8", pc, 32'h8);
        step(1); check("seq_c", pc, 32'hC);
        step(1); check("seq_10", pc, 32'h10);

        br_taken = 1; br_base = 32'h100; br_offset = 32'h20;
        step(1); check("br_120", pc, 32'h120);
        br_base = 32'h200; br_offset = 32'h21; br_jalr = 1;
        step(1); check("jalr_220", pc, 32'h220);
        clr(); stall = 1;
        step(2); check("stall_hold", pc, 32'h220); check("stall_valid", {31'd0, if_valid}, 32'd1);
        stall = 0;
        step(1); check("after_stall", pc, 32'h224);

        br_taken = 1; br_base = 32'h40; br_offset = 32'h0;
        step(1); check("br_40", pc, 32'h40);
        clr(); if_ready = 0;
        step(1); check("hold_40", pc, 32'h40);
        br_taken = 1; br_base = 32'h80;
        step(1); check("hold_br", pc, 32'h40);
        clr(); trap = 1; trap_vec = 32'h200;
        step(1); check("hold_trap", pc, 32'h40);
        clr(); if_ready = 1;
        step(1); check("release_trap", pc, 32'h200);

        trap = 1; trap_vec = 32'h280; mret = 1; mepc = 32'h300; br_taken = 1; br_base = 32'h500;
        step(1); check("prio_trap", pc, 32'h280);
        trap = 0;
        step(1); check("prio_mret", pc, 32'h300);
        clr(); br_taken = 1; br_base = 32'h100; br_offset = 32'h2;
        step(1); check("mis_pc", pc, 32'h280); check("mis_pulse", {31'd0, misalign}, 32'd1);
        clr();
        step(1); check("mis_end", {31'd0, misalign}, 32'd0); check("mis_next", pc, 32'h284);
        br_taken = 1; br_base = 32'hFFFF_FFF0; br_offset = 32'hC;
        step(1); check("wrap_pre", pc, 32'hFFFF_FFFC);
        clr();
        step(1); check("wrap_0", pc, 32'h0);

        if_ready = 0;
        step(1);
        trap = 1; trap_vec = 32'h280;
        step(1);
        clr(); br_taken = 1; br_base = 32'h800; br_offset = 32'h0;
        step(1);
        clr(); if_ready = 1;
        step(1); check("low_no_overwrite", pc, 32'h280);
        if_ready = 0;
        step(1);
        br_taken = 1; br_base = 32'h800;
        step(1);
        clr(); mret = 1; mepc = 32'h300;
        step(1);
        clr(); if_ready = 1;
        step(1); check("high_overwrites", pc, 32'h300);

        if_ready = 0;
        step(1);
        trap = 1; trap_vec = 32'h280;
        step(1);
        clr();
        rst_n = 0;
        #1 check("async_rst_pc", pc, RV);
        check("async_rst_valid", {31'd0, if_valid}, 32'd0);
        check("async_rst_mis", {31'd0, misalign}, 32'd0);
        step(1);
        rst_n = 1; if_ready = 1;
        step(1); check("post_rst_pc0", pc, 32'h0);
        step(1); check("post_rst_no_pend", pc, 32'h4);
        step(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
